// File: rtl/spi_ram_protocol_monitor.sv
// Passive SPI-RAM command/data monitor: shadow memory, read-data and tx_valid timing checks.
// Latency: error pulses 1 cycle after the detecting edge; never backpressures; MON_SVA_EN adds assertions/covers.
module spi_ram_protocol_monitor #(
  parameter int ADDR_SIZE    = 8,
  parameter int MEM_DEPTH    = 256,
  parameter int READ_TIMEOUT = 4,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] dout,
  input  logic                 tx_valid,
  output logic                 err_seq,
  output logic                 err_data,
  output logic                 err_tx,
  output logic                 err_timeout,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ERR_CNT_W-1:0] rd_checked
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int TW = $clog2(READ_TIMEOUT + 2);
  localparam int SW = ERR_CNT_W + 3;
  localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(MEM_DEPTH);
  localparam logic [1:0] CMD_WA = 2'b00, CMD_WD = 2'b01, CMD_RA = 2'b10, CMD_RD = 2'b11;

  typedef enum logic [1:0] {IDLE, WADDR, RADDR} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   waddr_q, waddr_d, raddr_q, raddr_d, exp_q, exp_d;
  logic                   pend_q, pend_d;
  logic [TW-1:0]          tcnt_q, tcnt_d, cur;
  logic [MEM_DEPTH-1:0]   valid_q, valid_d;
  logic [ADDR_SIZE-1:0]   shadow_q [MEM_DEPTH];
  logic                   err_seq_q, err_seq_d, err_data_q, err_data_d;
  logic                   err_tx_q, err_tx_d, err_timeout_q, err_timeout_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d, rd_checked_q, rd_checked_d;
  logic [SW-1:0]          cnt_sum;
  logic [1:0]             cmd;
  logic [ADDR_SIZE-1:0]   pay, chk_addr;
  logic                   tx_used, chk_req, chk_ok, shadow_we;

  assign cmd = din[ADDR_SIZE+1 -: 2];
  assign pay = din[ADDR_SIZE-1:0];
  assign cur = tcnt_q + TW'(1);

  always_comb begin
    state_d       = state_q;
    waddr_d       = waddr_q;
    raddr_d       = raddr_q;
    exp_d         = exp_q;
    pend_d        = pend_q;
    tcnt_d        = tcnt_q;
    valid_d       = valid_q;
    err_seq_d     = 1'b0;
    err_data_d    = 1'b0;
    err_tx_d      = 1'b0;
    err_timeout_d = 1'b0;
    tx_used       = 1'b0;
    chk_req       = 1'b0;
    chk_ok        = 1'b0;
    chk_addr      = exp_q;
    shadow_we     = 1'b0;

    // The outstanding read is resolved first so a same-cycle RD_DATA can re-arm.
    if (pend_q) begin
      if (tx_valid && (cur <= TW'(READ_TIMEOUT))) begin
        tx_used = 1'b1;
        chk_req = 1'b1;
        pend_d  = 1'b0;
      end else if (cur > TW'(READ_TIMEOUT)) begin
        err_timeout_d = 1'b1;
        pend_d        = 1'b0;
      end else begin
        tcnt_d = cur;
      end
    end

    if (rx_valid) begin
      unique case (cmd)
        CMD_WA: begin
          waddr_d = pay;
          state_d = WADDR;
        end
        CMD_WD: begin
          if (state_q == WADDR && ({1'b0, waddr_q} < DEPTH_C)) begin
            shadow_we                = 1'b1;
            valid_d[waddr_q[AW-1:0]] = 1'b1;
          end else begin
            err_seq_d = 1'b1;
          end
        end
        CMD_RA: begin
          raddr_d = pay;
          state_d = RADDR;
        end
        default: begin
          if (state_q == RADDR) begin
            state_d = IDLE;
            if ({1'b0, raddr_q} < DEPTH_C) begin
              if (pend_d) err_timeout_d = 1'b1;
              if (tx_valid && !tx_used) begin
                tx_used  = 1'b1;
                chk_req  = 1'b1;
                chk_addr = raddr_q;
                pend_d   = 1'b0;
              end else begin
                pend_d = 1'b1;
                exp_d  = raddr_q;
                tcnt_d = '0;
              end
            end else begin
              err_seq_d = 1'b1;
            end
          end else begin
            err_seq_d = 1'b1;
          end
        end
      endcase
    end

    if (tx_valid && !tx_used) err_tx_d = 1'b1;

    // Unwritten locations are not compared but still count as checked.
    if (chk_req) begin
      if (valid_q[chk_addr[AW-1:0]] && (shadow_q[chk_addr[AW-1:0]] != dout)) err_data_d = 1'b1;
      else chk_ok = 1'b1;
    end

    cnt_sum = SW'(err_count_q) + SW'(err_seq_d) + SW'(err_data_d) + SW'(err_tx_d) + SW'(err_timeout_d);
    err_count_d  = (|cnt_sum[SW-1:ERR_CNT_W]) ? '1 : cnt_sum[ERR_CNT_W-1:0];
    rd_checked_d = (chk_ok && rd_checked_q != '1) ? rd_checked_q + ERR_CNT_W'(1) : rd_checked_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      waddr_q       <= '0;
      raddr_q       <= '0;
      exp_q         <= '0;
      pend_q        <= 1'b0;
      tcnt_q        <= '0;
      valid_q       <= '0;
      err_seq_q     <= 1'b0;
      err_data_q    <= 1'b0;
      err_tx_q      <= 1'b0;
      err_timeout_q <= 1'b0;
      err_count_q   <= '0;
      rd_checked_q  <= '0;
    end else begin
      state_q       <= state_d;
      waddr_q       <= waddr_d;
      raddr_q       <= raddr_d;
      exp_q         <= exp_d;
      pend_q        <= pend_d;
      tcnt_q        <= tcnt_d;
      valid_q       <= valid_d;
      err_seq_q     <= err_seq_d;
      err_data_q    <= err_data_d;
      err_tx_q      <= err_tx_d;
      err_timeout_q <= err_timeout_d;
      err_count_q   <= err_count_d;
      rd_checked_q  <= rd_checked_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && shadow_we) shadow_q[waddr_q[AW-1:0]] <= pay;
  end

  assign err_seq     = err_seq_q;
  assign err_data    = err_data_q;
  assign err_tx      = err_tx_q;
  assign err_timeout = err_timeout_q;
  assign err_count   = err_count_q;
  assign rd_checked  = rd_checked_q;

`ifdef MON_SVA_EN
  logic acc_wa, acc_wd, acc_ra, acc_rd;
  assign acc_wa = rx_valid && (cmd == CMD_WA);
  assign acc_wd = rx_valid && (cmd == CMD_WD);
  assign acc_ra = rx_valid && (cmd == CMD_RA);
  assign acc_rd = rx_valid && (cmd == CMD_RD);

  a_err_seq:     assert property (@(posedge clk) disable iff (rst) !err_seq)     else $error("err_seq");
  a_err_data:    assert property (@(posedge clk) disable iff (rst) !err_data)    else $error("err_data");
  a_err_tx:      assert property (@(posedge clk) disable iff (rst) !err_tx)      else $error("err_tx");
  a_err_timeout: assert property (@(posedge clk) disable iff (rst) !err_timeout) else $error("err_timeout");

  c_full_read: cover property (@(posedge clk) disable iff (rst)
    acc_wa ##1 acc_wd ##1 acc_ra ##1 acc_rd ##[0:READ_TIMEOUT] tx_valid);
  c_b2b_write: cover property (@(posedge clk) disable iff (rst) acc_wd && state_q == WADDR ##1 acc_wd);
  c_timeout:   cover property (@(posedge clk) disable iff (rst) err_timeout);
`endif

endmodule

// File: tb/tb_spi_ram_protocol_monitor.sv
// Randomized and directed bench for spi_ram_protocol_monitor against a cycle-numbered reference model.
module tb_spi_ram_protocol_monitor;
  localparam int AS = 8;
  localparam int RT = 4;
  localparam int CW = 8;
  localparam int WA = 0, WD = 1, RA = 2, RD = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [AS+1:0] din;
  logic          rx_valid;
  logic [AS-1:0] dout;
  logic          tx_valid;
  logic          err_seq, err_data, err_tx, err_timeout;
  logic [CW-1:0] err_count, rd_checked;

  spi_ram_protocol_monitor #(.ADDR_SIZE(AS), .MEM_DEPTH(256), .READ_TIMEOUT(RT), .ERR_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid), .dout(dout), .tx_valid(tx_valid),
    .err_seq(err_seq), .err_data(err_data), .err_tx(err_tx), .err_timeout(err_timeout),
    .err_count(err_count), .rd_checked(rd_checked)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: addresses latched by the last address command, a pending read
  // identified by the cycle number it was accepted on, and a sparse shadow map.
  int cyc = 0;
  int m_mode = 0;            // 0: no address latched, 1: write address, 2: read address
  int m_waddr = 0, m_raddr = 0, m_exp = 0, m_acc = 0;
  bit m_pend = 0;
  int shadow_m [int];
  int m_cnt = 0, m_chk = 0;
  bit e_seq = 0, e_dat = 0, e_tx = 0, e_to = 0;

  task automatic model_step();
    int c, p, age, caddr;
    bit used, do_chk, wr, ok;
    c = int'(din[AS+1:AS]);
    p = int'(din[AS-1:0]);
    used = 0; do_chk = 0; wr = 0; ok = 0; caddr = 0;
    if (rst) begin
      m_mode = 0; m_pend = 0; shadow_m.delete(); m_cnt = 0; m_chk = 0;
      e_seq = 0; e_dat = 0; e_tx = 0; e_to = 0;
    end else begin
      e_seq = 0; e_dat = 0; e_tx = 0; e_to = 0;
      if (m_pend) begin
        age = cyc - m_acc;
        if (tx_valid && age <= RT) begin used = 1; do_chk = 1; caddr = m_exp; m_pend = 0; end
        else if (age > RT) begin e_to = 1; m_pend = 0; end
      end
      if (rx_valid) begin
        if (c == WA) begin m_waddr = p; m_mode = 1; end
        else if (c == WD) begin if (m_mode == 1) wr = 1; else e_seq = 1; end
        else if (c == RA) begin m_raddr = p; m_mode = 2; end
        else if (m_mode == 2) begin
          m_mode = 0;
          if (m_pend) e_to = 1;
          if (tx_valid && !used) begin used = 1; do_chk = 1; caddr = m_raddr; m_pend = 0; end
          else begin m_pend = 1; m_exp = m_raddr; m_acc = cyc; end
        end else e_seq = 1;
      end
      e_tx = tx_valid && !used;
      if (do_chk) begin
        if (shadow_m.exists(caddr) && shadow_m[caddr] != int'(dout)) e_dat = 1;
        else ok = 1;
      end
      if (wr) shadow_m[m_waddr] = p;
      m_cnt = m_cnt + int'(e_seq) + int'(e_dat) + int'(e_tx) + int'(e_to);
      if (m_cnt > 255) m_cnt = 255;
      if (ok && m_chk < 255) m_chk = m_chk + 1;
    end
    cyc++;
  endtask

  task automatic drive(input bit rv, input int c, input int p, input bit tv, input int d);
    rx_valid = rv;
    din      = {c[1:0], p[AS-1:0]};
    tx_valid = tv;
    dout     = d[AS-1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({err_seq, err_data, err_tx, err_timeout} !== 4'b0 || err_count !== 8'd0 || rd_checked !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_state: flags=%b cnt=%0d chk=%0d, required all zero",
               {err_seq, err_data, err_tx, err_timeout}, err_count, rd_checked);
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, $urandom % 4, $urandom % 256, 0, $urandom % 256);
      tick();
      n_checks++;
      if ({err_seq, err_data, err_tx, err_timeout} !== 4'b0 || err_count !== 8'd0 || rd_checked !== 8'd0) begin
        n_errors++;
        $display("FAIL reset_idle: flags=%b cnt=%0d chk=%0d, required all zero",
                 {err_seq, err_data, err_tx, err_timeout}, err_count, rd_checked);
      end
    end
  endtask

  task automatic test_write_read(input int rd_val, input bit expect_bad);
    do_reset();
    drive(1, WA, 8'h1A, 0, 0); tick();
    drive(1, WD, 8'h5C, 0, 0); tick();
    drive(1, RA, 8'h1A, 0, 0); tick();
    drive(1, RD, 0, 0, 0);     tick();
    drive(0, 0, 0, 1, rd_val); tick();
    n_checks++;
    if (err_data !== expect_bad || err_count !== (expect_bad ? 8'd1 : 8'd0) ||
        rd_checked !== (expect_bad ? 8'd0 : 8'd1)) begin
      n_errors++;
      $display("FAIL write_read(%0h): err_data=%b cnt=%0d chk=%0d, required %b/%0d/%0d", rd_val,
               err_data, err_count, rd_checked, expect_bad, expect_bad ? 1 : 0, expect_bad ? 0 : 1);
    end
    drive(0, 0, 0, 0, 0); tick();
    n_checks++;
    if (err_data !== 1'b0 || err_tx !== 1'b0 || err_count !== (expect_bad ? 8'd1 : 8'd0)) begin
      n_errors++;
      $display("FAIL write_read_after(%0h): err_data=%b err_tx=%b cnt=%0d, required 0/0/%0d",
               rd_val, err_data, err_tx, err_count, expect_bad ? 1 : 0);
    end
  endtask

  task automatic test_seq_tx();
    do_reset();
    drive(1, RD, 0, 0, 0); tick();
    n_checks++;
    if (err_seq !== 1'b1 || err_count !== 8'd1) begin
      n_errors++;
      $display("FAIL seq_rd_idle: err_seq=%b cnt=%0d, required 1/1", err_seq, err_count);
    end
    drive(0, 0, 0, 1, 0); tick();
    n_checks++;
    if (err_seq !== 1'b0 || err_tx !== 1'b1 || err_count !== 8'd2) begin
      n_errors++;
      $display("FAIL tx_no_pending: err_seq=%b err_tx=%b cnt=%0d, required 0/1/2", err_seq, err_tx, err_count);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    drive(1, RA, 8'h03, 0, 0); tick();
    drive(1, RD, 0, 0, 0);     tick();
    for (int k = 1; k <= 6; k++) begin
      drive(0, 0, 0, 0, 0); tick();
      n_checks++;
      if (err_timeout !== (k == 5)) begin
        n_errors++;
        $display("FAIL timeout_cycle%0d: err_timeout=%b, required %b", k, err_timeout, k == 5);
      end
    end
    n_checks++;
    if (err_count !== 8'd1) begin
      n_errors++;
      $display("FAIL timeout_count: err_count=%0d, required 1", err_count);
    end
    drive(1, RA, 8'h03, 0, 0); tick();
    drive(1, RD, 0, 0, 0);     tick();
    drive(0, 0, 0, 0, 0); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (err_timeout !== 1'b0 || err_count !== 8'd0) begin
        n_errors++;
        $display("FAIL reset_drops_read%0d: err_timeout=%b cnt=%0d, required 0/0", k, err_timeout, err_count);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1, WA, 8'h05, 0, 0); tick();
    drive(1, WD, 8'h77, 0, 0); tick();
    drive(1, RA, 8'h05, 0, 0); tick();
    drive(1, RD, 0, 1, 8'h77); tick();
    n_checks++;
    if (err_count !== 8'd0 || rd_checked !== 8'd1) begin
      n_errors++;
      $display("FAIL zero_latency: cnt=%0d chk=%0d, required 0/1", err_count, rd_checked);
    end
    drive(1, RA, 8'h05, 0, 0); tick();
    drive(1, RD, 0, 0, 0);     tick();
    drive(1, RA, 8'h06, 0, 0); tick();
    drive(1, RD, 0, 0, 0);     tick();
    n_checks++;
    if (err_timeout !== 1'b1 || err_count !== 8'd1) begin
      n_errors++;
      $display("FAIL replace_read: err_timeout=%b cnt=%0d, required 1/1", err_timeout, err_count);
    end
    drive(0, 0, 0, 1, $urandom % 256); tick();
    n_checks++;
    if (err_tx !== 1'b0 || err_data !== 1'b0 || rd_checked !== 8'd2) begin
      n_errors++;
      $display("FAIL unwritten_read: err_tx=%b err_data=%b chk=%0d, required 0/0/2", err_tx, err_data, rd_checked);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_checks++;
      if (err_tx !== 1'b1 || err_count !== 8'(2 + k)) begin
        n_errors++;
        $display("FAIL tx_held%0d: err_tx=%b cnt=%0d, required 1/%0d", k, err_tx, err_count, 2 + k);
      end
    end
    drive(1, WA, 8'h09, 0, 0); tick();
    drive(1, WD, 8'h11, 0, 0); tick();
    drive(1, WD, 8'h22, 0, 0); tick();
    drive(1, RA, 8'h09, 0, 0); tick();
    drive(1, RD, 0, 0, 0);     tick();
    drive(0, 0, 0, 0, 0);      tick();
    drive(0, 0, 0, 1, 8'h22);  tick();
    n_checks++;
    if (err_seq !== 1'b0 || err_data !== 1'b0 || err_count !== 8'd3 || rd_checked !== 8'd3) begin
      n_errors++;
      $display("FAIL b2b_write: seq=%b data=%b cnt=%0d chk=%0d, required 0/0/3/3",
               err_seq, err_data, err_count, rd_checked);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      drive(1, WD, $urandom % 256, 0, 0); tick();
      if (i % 50 == 0 || i == 255 || i == 256) begin
        n_checks++;
        if (err_seq !== 1'b1 || err_count !== 8'((i > 255) ? 255 : i)) begin
          n_errors++;
          $display("FAIL saturate%0d: err_seq=%b cnt=%0d, required 1/%0d", i, err_seq, err_count,
                   (i > 255) ? 255 : i);
        end
      end
    end
  endtask

  task automatic test_random();
    int c, p, d, tgt;
    bit rv, tv;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 250 == 0);
      rv = ($urandom % 3 != 0);
      c  = $urandom % 4;
      p  = (c == WD) ? $urandom % 256 : $urandom % 8;
      tv = (m_pend || (rv && c == RD)) ? ($urandom % 3 == 0) : ($urandom % 25 == 0);
      tgt = m_pend ? m_exp : m_raddr;
      if (shadow_m.exists(tgt) && $urandom % 4 != 0) d = shadow_m[tgt];
      else d = $urandom % 256;
      drive(rv, c, p, tv, d);
      tick();
      n_checks++;
      if (err_seq !== e_seq || err_data !== e_dat || err_tx !== e_tx || err_timeout !== e_to ||
          err_count !== 8'(m_cnt) || rd_checked !== 8'(m_chk)) begin
        n_errors++;
        $display("FAIL random%0d: seq/data/tx/to=%b%b%b%b cnt=%0d chk=%0d, required %b%b%b%b cnt=%0d chk=%0d",
                 i, err_seq, err_data, err_tx, err_timeout, err_count, rd_checked,
                 e_seq, e_dat, e_tx, e_to, m_cnt, m_chk);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_write_read(8'h5C, 1'b0);
    test_write_read(8'h5D, 1'b1);
    test_seq_tx();
    test_timeout();
    test_back_to_back();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
